// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the FIR datapath stages.
//   - DIN_W / DOUT_W : FIR output width and requantised output width.
//   - SAT_MAX        : saturation ceiling of the requantised word.
//   - rq_t           : requantised word plus its saturation flag.
//   - round_shift_sat: round-to-nearest, right shift, saturate to DOUT_W.
// ----------------------------------------------------------------------------
package fir_pkg;

   localparam int DIN_W  = 16;
   localparam int DOUT_W = 8;

   // Ceiling expressed in the DIN_W+1 bit intermediate domain.
   localparam logic [DIN_W:0] SAT_MAX = (DIN_W+1)'((1 << DOUT_W) - 1);

   typedef struct packed {
      logic              sat;
      logic [DOUT_W-1:0] data;
   } rq_t;

   // The sum is formed one bit wider than the input so that adding the
   // rounding constant to a near-full-scale sample can never wrap.
   function automatic rq_t round_shift_sat(input logic [DIN_W-1:0] x,
                                           input int               shift);
      logic [DIN_W:0] sum;
      logic [DIN_W:0] r;
      rq_t            res;
      sum = {1'b0, x} + ((DIN_W+1)'(1) << (shift - 1));
      r   = sum >> shift;
      if (r > SAT_MAX) begin
         res.sat  = 1'b1;
         res.data = '1;
      end else begin
         res.sat  = 1'b0;
         res.data = r[DOUT_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// ----------------------------------------------------------------------------
// fir_sync_fifo
//   Single-clock first-word-fall-through FIFO with registered storage.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     wr_en_i, wr_data_i : write request and data (dropped when full unless
//                          a read happens on the same edge)
//     rd_en_i         : consumer ready; a read happens when rd_en_i & valid_o
//     rd_data_o       : head word (meaningful while valid_o=1)
//     valid_o         : FIFO not empty
//     full_o          : FIFO holds DEPTH words
//     level_o         : occupancy 0..DEPTH
//   Handshake: a word transfers on a rising edge where valid_o=1 and
//   rd_en_i=1; rd_data_o is stable while valid_o=1 and rd_en_i=0.
// ----------------------------------------------------------------------------
module fir_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       valid_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             empty;
   logic             do_rd;
   logic             do_wr;

   assign empty  = (level_q == '0);
   assign full_o = (level_q == LW'(DEPTH));

   // A write into a full FIFO is still legal when the head is read on the
   // same edge: the slot being freed is the one being written.
   assign do_rd = rd_en_i & ~empty;
   assign do_wr = wr_en_i & (~full_o | do_rd);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         if (do_wr) mem_q[wptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rptr_q];
   assign valid_o   = ~empty;
   assign level_o   = level_q;

endmodule

// File: rtl/fir_out_decim.sv
// ----------------------------------------------------------------------------
// fir_out_decim
//   Output stage behind the 3-tap FIR: round/shift/saturate each sample to
//   DOUT_W bits, keep 1 of every DECIM accepted samples, buffer kept words in
//   a FWFT FIFO, and keep saturation / overflow statistics.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     yin, yin_en   : FIR sample and its strobe
//     clr_stat      : synchronous clear of ovf_sticky and sat_cnt
//     out_data      : head-of-FIFO sample
//     out_valid     : FIFO not empty
//     out_ready     : consumer accepts out_data when out_valid & out_ready
//     fifo_level    : FIFO occupancy 0..DEPTH
//     ovf_sticky    : a kept sample was dropped because the FIFO was full
//     sat_cnt       : saturated kept samples, saturating at 255
//   Latency: a kept sample accepted on edge k is visible on out_data after
//   edge k+1.
// ----------------------------------------------------------------------------
module fir_out_decim
   import fir_pkg::*;
#(
   parameter int DIN_W  = fir_pkg::DIN_W,
   parameter int DOUT_W = fir_pkg::DOUT_W,
   parameter int SHIFT  = 4,
   parameter int DECIM  = 2,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DIN_W-1:0]       yin,
   input  logic                   yin_en,
   input  logic                   clr_stat,
   output logic [DOUT_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   ovf_sticky,
   output logic [7:0]             sat_cnt
);

   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   rq_t               rq;
   logic              keep;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              s1_vld_q, s1_vld_d;
   logic [DOUT_W-1:0] s1_data_q, s1_data_d;
   logic              s1_sat_q, s1_sat_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        sat_cnt_q, sat_cnt_d;
   logic              fifo_full;

   assign rq   = round_shift_sat(yin, SHIFT);
   assign keep = (phase_q == '0);

   // Stage 1: requantise and decide keep; stage-1 valid already means
   // "valid and kept", so discarded samples never reach the FIFO or stats.
   always_comb begin
      phase_d   = phase_q;
      s1_vld_d  = yin_en & keep;
      s1_data_d = s1_data_q;
      s1_sat_d  = s1_sat_q;
      if (yin_en) begin
         s1_data_d = rq.data;
         s1_sat_d  = rq.sat;
         phase_d   = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
      end
   end

   // Statistics: clear wins over any coincident set/increment.
   always_comb begin
      ovf_d     = ovf_q;
      sat_cnt_d = sat_cnt_q;
      if (clr_stat) begin
         ovf_d     = 1'b0;
         sat_cnt_d = '0;
      end else begin
         if (s1_vld_q && fifo_full && !(out_valid && out_ready)) ovf_d = 1'b1;
         if (s1_vld_q && s1_sat_q && (sat_cnt_q != 8'hFF))
            sat_cnt_d = sat_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= '0;
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_sat_q  <= 1'b0;
         ovf_q     <= 1'b0;
         sat_cnt_q <= '0;
      end else begin
         phase_q   <= phase_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_sat_q  <= s1_sat_d;
         ovf_q     <= ovf_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   fir_sync_fifo #(
      .WIDTH (DOUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (s1_vld_q),
      .wr_data_i (s1_data_q),
      .rd_en_i   (out_ready),
      .rd_data_o (out_data),
      .valid_o   (out_valid),
      .full_o    (fifo_full),
      .level_o   (fifo_level)
   );

   assign ovf_sticky = ovf_q;
   assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// ----------------------------------------------------------------------------
// tb_fir_out_decim
//   Directed scenarios with literal expectations, followed by a randomized
//   run; a queue-based reference model is compared against the DUT on every
//   falling clock edge.
//   Handshake: out_data transfers on a rising edge where out_valid=1 and
//   out_ready=1.
// ----------------------------------------------------------------------------
module tb_fir_out_decim;

   localparam int DEPTH = 4;
   localparam int DECIM = 2;
   localparam int SHIFT = 4;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] yin = '0;
   logic        yin_en = 1'b0;
   logic        clr_stat = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [2:0]  fifo_level;
   logic        ovf_sticky;
   logic [7:0]  sat_cnt;

   fir_out_decim #(.SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .yin        (yin),
      .yin_en     (yin_en),
      .clr_stat   (clr_stat),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .ovf_sticky (ovf_sticky),
      .sat_cnt    (sat_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];     // words the FIFO must hold, head first
   logic [7:0] got_q[$];     // words the consumer actually took
   bit         pend_v;
   logic [7:0] pend_d;
   bit         pend_s;
   int         m_phase;
   bit         m_ovf;
   int         m_sat;
   int         rst_evt  = 0;
   int         rst_seen = 0;

   initial forever begin
      @(negedge rst_n);
      rst_evt++;
   end

   task automatic model_clear();
      exp_q.delete();
      pend_v  = 0;
      pend_d  = '0;
      pend_s  = 0;
      m_phase = 0;
      m_ovf   = 0;
      m_sat   = 0;
   endtask

   task automatic sync_rst();
      if (rst_evt != rst_seen || !rst_n) begin
         model_clear();
         rst_seen = rst_evt;
      end
   endtask

   // Sample value after rounding to nearest and dividing by 2^SHIFT.
   task automatic ref_requant(input logic [15:0] y, output logic [7:0] d, output bit s);
      int r;
      r = (int'(y) + (1 << (SHIFT - 1))) / (1 << SHIFT);
      if (r > 255) begin d = 8'd255; s = 1; end
      else begin d = 8'(r); s = 0; end
   endtask

   // Applied at each rising edge, using the inputs present before the edge.
   task automatic model_step();
      bit rd, full, ovf_set, sat_inc;
      if (!rst_n) begin
         model_clear();
         return;
      end
      rd      = (exp_q.size() > 0) && out_ready;
      full    = (exp_q.size() == DEPTH);
      ovf_set = 0;
      sat_inc = 0;
      if (rd) void'(exp_q.pop_front());
      if (pend_v) begin
         if (!full || rd) exp_q.push_back(pend_d);
         else ovf_set = 1;
         if (pend_s) sat_inc = 1;
      end
      if (clr_stat) begin
         m_ovf = 0;
         m_sat = 0;
      end else begin
         if (ovf_set) m_ovf = 1;
         if (sat_inc && m_sat < 255) m_sat++;
      end
      pend_v = yin_en && (m_phase == 0);
      if (yin_en) begin
         ref_requant(yin, pend_d, pend_s);
         m_phase = (m_phase + 1) % DECIM;
      end
   endtask

   // scoreboard / compare process
   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         sync_rst();
         model_step();
         @(negedge clk);
         sync_rst();
         chk("out_valid", out_valid, exp_q.size() > 0);
         if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
         chk("fifo_level", fifo_level, exp_q.size());
         chk("ovf_sticky", ovf_sticky, m_ovf);
         chk("sat_cnt", sat_cnt, m_sat);
         if (out_valid && out_ready) got_q.push_back(out_data);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit en, input logic [15:0] y, input bit rdy, input bit clr);
      yin_en    = en;
      yin       = y;
      out_ready = rdy;
      clr_stat  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      yin_en    = 0;
      yin       = '0;
      out_ready = 0;
      clr_stat  = 0;
      rst_n     = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      got_q.delete();
   endtask

   task automatic chk_got(input string name, input int idx, input int exp);
      if (idx < got_q.size()) chk(name, got_q[idx], exp);
      else chk(name, -1, exp);
   endtask

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      chk("reset_valid", out_valid, 0);
      chk("reset_level", fifo_level, 0);
      chk("reset_ovf", ovf_sticky, 0);
      chk("reset_sat", sat_cnt, 0);
      chk("reset_data", out_data, 0);

      // rounding boundary: 0x0007 -> 0, 0x0008 -> 1, 0x0168 -> 23
      drive(1, 16'h0007, 1, 0);
      chk("rnd_lat_lo", out_valid, 0);
      drive(1, 16'hAAAA, 1, 0);
      chk("rnd_lat_valid", out_valid, 1);
      chk("rnd_lat_data", out_data, 0);
      drive(1, 16'h0008, 1, 0);
      drive(1, 16'h5555, 1, 0);
      drive(1, 16'h0168, 1, 0);
      repeat (3) drive(0, 0, 1, 0);
      chk("rnd_count", got_q.size(), 3);
      chk_got("rnd_0", 0, 0);
      chk_got("rnd_1", 1, 1);
      chk_got("rnd_2", 2, 23);
      chk("rnd_sat", sat_cnt, 0);

      // FIR-style stream: 30,70,110,150 -> 2, 7
      do_reset();
      drive(1, 16'd30, 1, 0);
      drive(1, 16'd70, 1, 0);
      drive(1, 16'd110, 1, 0);
      drive(1, 16'd150, 1, 0);
      repeat (4) drive(0, 0, 1, 0);
      chk("fir_count", got_q.size(), 2);
      chk_got("fir_0", 0, 2);
      chk_got("fir_1", 1, 7);

      // saturation then clear
      do_reset();
      drive(1, 16'hFFFF, 1, 0);
      drive(1, 16'h0000, 1, 0);
      drive(1, 16'h0FF8, 1, 0);
      repeat (3) drive(0, 0, 1, 0);
      chk_got("sat_0", 0, 255);
      chk_got("sat_1", 1, 255);
      chk("sat_cnt2", sat_cnt, 2);
      drive(0, 0, 1, 1);
      chk("sat_clr", sat_cnt, 0);

      // overflow: six kept samples into a stalled 4-deep FIFO
      do_reset();
      for (int n = 1; n <= 6; n++) begin
         drive(1, 16'(16 * n), 0, 0);
         drive(1, 16'h0000, 0, 0);
      end
      chk("ovf_level", fifo_level, 4);
      chk("ovf_sticky", ovf_sticky, 1);
      repeat (6) drive(0, 0, 1, 0);
      chk("ovf_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) chk_got("ovf_order", i, i + 1);
      chk("ovf_drain_level", fifo_level, 0);

      // full FIFO with simultaneous read and write
      do_reset();
      for (int n = 1; n <= 4; n++) begin
         drive(1, 16'(16 * n), 0, 0);
         drive(1, 16'h0000, 0, 0);
      end
      chk("full_level", fifo_level, 4);
      drive(1, 16'd80, 0, 0);
      drive(0, 0, 1, 0);
      chk("rw_level", fifo_level, 4);
      chk("rw_ovf", ovf_sticky, 0);
      repeat (6) drive(0, 0, 1, 0);
      chk("rw_count", got_q.size(), 5);
      for (int i = 0; i < 5; i++) chk_got("rw_order", i, i + 1);

      // asynchronous reset pulse mid-operation (level 3, phase 1)
      do_reset();
      drive(1, 16'd16, 0, 0);
      drive(1, 16'd0, 0, 0);
      drive(1, 16'd32, 0, 0);
      drive(1, 16'd0, 0, 0);
      drive(1, 16'd48, 0, 0);
      drive(0, 0, 0, 0);
      chk("pre_rst_level", fifo_level, 3);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_level", fifo_level, 0);
      #8 rst_n = 1;
      @(posedge clk);
      #1;
      drive(1, 16'd144, 1, 0);
      chk("post_rst_lat", out_valid, 0);
      drive(0, 0, 1, 0);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 9);
      drive(0, 0, 1, 0);

      // randomized run
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] y;
         if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(16'h0FE0, 16'hFFFF));
         else y = 16'($urandom_range(0, 16'h0FFF));
         drive($urandom_range(0, 9) < 8, y, $urandom_range(0, 1) == 1,
               $urandom_range(0, 49) == 0);
      end
      repeat (8) drive(0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_out_decim.md
Name: fir_out_decim

Overview:
- Output stage placed directly downstream of the 3-tap FIR. It consumes the FIR's 16-bit unsigned output stream.
- Each sample is round-to-nearest requantised to 8 bits and saturated. The stream is then decimated by a fixed factor.
- Kept samples are buffered in a small FIFO and presented through a valid/ready interface to the next consumer, e.g. a DAC/serialiser.
- Saturation and overflow statistics are kept for software visibility.

Parameters:
- DIN_W, 16, input sample width (FIR output width).
- DOUT_W, 8, output sample width.
- SHIFT, 4, right-shift applied after rounding; must be >= 1.
- DECIM, 2, decimation factor; keep 1 of every DECIM accepted samples; must be >= 1.
- DEPTH, 4, FIFO depth in words; power of two, >= 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset.
- yin  in  DIN_W  FIR output sample, unsigned.
- yin_en  in  1  sample strobe; yin is accepted on any rising edge where yin_en=1.
- clr_stat  in  1  synchronous clear of ovf_sticky and sat_cnt.
- out_data  out  DOUT_W  head-of-FIFO sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- ovf_sticky  out  1  set when a kept sample was dropped because the FIFO was full.
- sat_cnt  out  8  count of saturated kept samples; saturates at 255.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low: clock port clk, reset port rst_n.
  - Reset clears all state: stage-1 valid=0, decimation phase=0, FIFO pointers=0, out_valid=0, out_data=0, fifo_level=0, ovf_sticky=0, sat_cnt=0.
  - Reset asserted mid-operation discards all buffered and in-flight samples.
  - Output only restarts on the first yin_en after rst_n deasserts, with phase 0.
- Arithmetic (unsigned, DIN_W+1 bit intermediate):
  - r = (yin + 2^(SHIFT-1)) >> SHIFT.
  - If r > 2^DOUT_W-1, the result is 2^DOUT_W-1 and the sample is flagged sat. Otherwise the result is r[DOUT_W-1:0].
  - No wrap-around is permitted anywhere in this path.
- Decimation:
  - The phase counter runs 0..DECIM-1 and advances only on yin_en, wrapping from DECIM-1 to 0.
  - A sample is kept when phase==0 at acceptance. DECIM=1 keeps every sample.
- Pipeline and latency:
  - Edge k: yin accepted. The stage-1 register captures the result, the sat flag and keep.
  - Edge k+1: a kept stage-1 word is written into the FIFO.
  - With an empty FIFO, out_valid rises and out_data is valid after edge k+1, i.e. 2 cycles from acceptance.
  - The FIFO is first-word-fall-through with registered storage. out_data is held stable while out_valid=1 and out_ready=0.
- FIFO rules:
  - Read occurs when out_valid & out_ready. Write occurs when stage-1 is valid and kept.
  - Write with FIFO full and no simultaneous read: the word is dropped (newest lost) and ovf_sticky is set. Stored contents are unchanged.
  - Write with FIFO full and a simultaneous read: both happen and the level stays at DEPTH. No overflow.
  - Read with FIFO empty: ignored. Ready without valid has no effect.
  - Write and read on the same cycle with level 0: the word is written. out_valid rises the next cycle; there is no same-cycle bypass.
  - fifo_level is updated every edge as +1 / -1 / 0.
- Statistics:
  - sat_cnt increments by 1 when a kept sat word is written or dropped, saturating at 255.
  - Discarded (decimated-out) samples never count.
  - clr_stat=1 zeroes ovf_sticky and sat_cnt on that edge.
  - If a set or increment event coincides with clr_stat, clear wins.

Decomposition:
- Shared package fir_pkg:
  - Widths DIN_W/DOUT_W.
  - Constant for the saturation ceiling.
  - Function for round-shift-saturate, reusable by other stages.
- One sub-module: fir_sync_fifo (DEPTH, width DOUT_W, FWFT, level output).
- Requant, decimation and stats stay in the top module.

Test Plan (SHIFT=4, DECIM=2, DEPTH=4):
- Rounding boundary: out_ready=1; yin sequence 0x0007, x, 0x0008, x, 0x0168 (x = discarded) -> out_data 0, 1, 23 (0x17). Each appears 2 cycles after acceptance; sat_cnt=0.
- FIR-style stream: yin_en every cycle with yin = 30, 70, 110, 150 -> kept 30 and 110 -> out_data 2, then 7. Exactly 2 outputs.
- Saturation: yin=0xFFFF then 0x0FF8 (both kept, DECIM=1 build or on phase 0) -> out_data 255 both, sat_cnt=2. Then clr_stat -> sat_cnt=0.
- Overflow:
  - out_ready=0, 6 kept samples with values 1..6 (yin = 16*n) -> fifo_level=4, ovf_sticky=1.
  - Then out_ready=1 -> reads 1, 2, 3, 4 in order, and fifo_level returns to 0.
- Full with simultaneous read/write: level=4, out_ready=1 on the cycle a kept word arrives -> level stays 4, ovf_sticky stays 0, order preserved.
- Reset mid-operation: level=3 and phase=1, pulse rst_n low for 1 cycle asynchronously (not clock-aligned).
  - out_valid=0, fifo_level=0 immediately.
  - The next accepted sample is kept (phase 0) and appears 2 cycles later.
